// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready handshake and synchronous flush.
// Define IMM_FUSE_EN to fuse an UPPER followed by LOW10 into a single immediate.
module imm_gen_pipe #(
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 4,
  parameter int HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:31]       in_instr,
  input  logic [2:0]        in_fmt,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:DATA_W-1] out_imm,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_fused
);
  localparam logic [2:0] F_S12   = 3'd1;
  localparam logic [2:0] F_U18   = 3'd2;
  localparam logic [2:0] F_UPPER = 3'd3;
  localparam logic [2:0] F_BR14  = 3'd4;
  localparam logic [2:0] F_S12A  = 3'd5;
  localparam logic [2:0] F_LOW10 = 3'd6;

  typedef struct packed {
    logic [DATA_W-1:0] imm;
    logic [TAG_W-1:0]  tag;
  } resp_t;

  logic [31:0]       w_ins;
  logic [31:0]       w_imm32;
  logic [DATA_W-1:0] w_ext;
  logic              w_slot_free;
  logic              w_acc;
  logic              w_unused_hi;
  resp_t             r_out;
  logic              r_out_valid;

  // Big-endian bit numbering: instr bit 31 is the numeric LSB.
  assign w_ins       = in_instr;
  assign w_unused_hi = ^w_ins[31:22];

  always_comb begin
    w_imm32 = '0;
    case (in_fmt)
      F_S12, F_S12A: w_imm32 = {{20{w_ins[11]}}, w_ins[11:0]};
      F_U18:         w_imm32 = {14'b0, w_ins[17:0]};
      F_UPPER:       w_imm32 = {w_ins[21:0], 10'b0};
      F_BR14:        w_imm32 = {{16{w_ins[13]}}, w_ins[13:0], 2'b00};
      F_LOW10:       w_imm32 = {22'b0, w_ins[9:0]};
      default:       w_imm32 = '0;
    endcase
  end

  assign w_ext       = DATA_W'($signed(w_imm32));
  assign w_slot_free = !r_out_valid || out_ready;
  assign out_valid   = r_out_valid;
  assign out_imm     = r_out.imm;
  assign out_tag     = r_out.tag;

`ifdef IMM_FUSE_EN
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_SPILL} state_t;
  localparam int CNT_W = $clog2(HOLD_MAX + 1);

  state_t             r_state;
  logic [31:0]        r_pend_val;
  logic [TAG_W-1:0]   r_pend_tag;
  resp_t              r_spill;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_out_fused;
  logic [DATA_W-1:0]  w_pend_ext;
  logic [DATA_W-1:0]  w_fuse_ext;

  // Pending low 10 bits are always zero, so OR-ing LOW10 in is exact.
  assign w_pend_ext = DATA_W'($signed(r_pend_val));
  assign w_fuse_ext = DATA_W'($signed(r_pend_val | {22'b0, w_ins[9:0]}));
  assign in_ready   = rst_n && !flush && (r_state != S_SPILL) && w_slot_free;
  assign w_acc      = in_valid && in_ready;
  assign out_fused  = r_out_fused;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_out_fused <= 1'b0;
      r_state     <= S_IDLE;
      r_pend_val  <= '0;
      r_pend_tag  <= '0;
      r_spill     <= '0;
      r_cnt       <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_state     <= S_IDLE;
      r_pend_val  <= '0;
      r_pend_tag  <= '0;
      r_spill     <= '0;
      r_cnt       <= '0;
    end else begin
      if (w_slot_free) r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            if (in_fmt == F_UPPER) begin
              r_pend_val <= w_imm32;
              r_pend_tag <= in_tag;
              r_cnt      <= '0;
              r_state    <= S_HOLD;
            end else begin
              r_out_valid <= 1'b1;
              r_out       <= '{imm: w_ext, tag: in_tag};
              r_out_fused <= 1'b0;
            end
          end
        end
        S_HOLD: begin
          if (w_acc) begin
            r_cnt       <= '0;
            r_out_valid <= 1'b1;
            case (in_fmt)
              F_LOW10: begin
                r_out       <= '{imm: w_fuse_ext, tag: r_pend_tag};
                r_out_fused <= 1'b1;
                r_state     <= S_IDLE;
              end
              F_UPPER: begin
                r_out       <= '{imm: w_pend_ext, tag: r_pend_tag};
                r_out_fused <= 1'b0;
                r_pend_val  <= w_imm32;
                r_pend_tag  <= in_tag;
              end
              default: begin
                r_out       <= '{imm: w_pend_ext, tag: r_pend_tag};
                r_out_fused <= 1'b0;
                r_spill     <= '{imm: w_ext, tag: in_tag};
                r_state     <= S_SPILL;
              end
            endcase
          end else if (r_cnt == CNT_W'(HOLD_MAX)) begin
            // Timed out: release pending alone once the output slot is free.
            if (w_slot_free) begin
              r_out_valid <= 1'b1;
              r_out       <= '{imm: w_pend_ext, tag: r_pend_tag};
              r_out_fused <= 1'b0;
              r_cnt       <= '0;
              r_state     <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SPILL: begin
          if (w_slot_free) begin
            r_out_valid <= 1'b1;
            r_out       <= r_spill;
            r_out_fused <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  assign in_ready  = rst_n && !flush && w_slot_free;
  assign w_acc     = in_valid && in_ready;
  assign out_fused = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else begin
      if (w_slot_free) r_out_valid <= 1'b0;
      if (w_acc) begin
        r_out_valid <= 1'b1;
        r_out       <= '{imm: w_ext, tag: in_tag};
      end
    end
  end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe (DATA_W=64): cycle-level reference model plus directed literal checks.
// Build with IMM_FUSE_EN to exercise the fusion FSM.
module tb_imm_gen_pipe;
  localparam int DW = 64;
  localparam int TW = 4;
  localparam int HM = 4;
`ifdef IMM_FUSE_EN
  localparam bit FUSE = 1'b1;
`else
  localparam bit FUSE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b1;
  logic          in_ready;
  logic [0:31]   in_instr = '0;
  logic [2:0]    in_fmt = 3'd1;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [0:DW-1] out_imm;
  logic [TW-1:0] out_tag;
  logic          out_fused;

  imm_gen_pipe #(.DATA_W(DW), .TAG_W(TW), .HOLD_MAX(HM)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_fmt(in_fmt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_tag(out_tag), .out_fused(out_fused)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [DW-1:0] imm;
    logic [TW-1:0] tag;
    bit            fused;
  } xfer_t;
  xfer_t xlog[$];
  bit    s_ir;

  // Reference model: output slot, pending upper, spill slot, idle counter.
  bit            m_ov;
  logic [DW-1:0] m_imm;
  logic [TW-1:0] m_tag;
  bit            m_fused;
  int            m_st;     // 0 no pending, 1 upper pending, 2 spill waiting
  logic [DW-1:0] m_pend;
  logic [TW-1:0] m_ptag;
  int            m_cnt;
  logic [DW-1:0] m_sp;
  logic [TW-1:0] m_stag;

  function automatic logic [DW-1:0] ref_imm(input logic [2:0] f, input logic [31:0] x);
    longint t;
    t = 0;
    case (f)
      3'd1, 3'd5: begin t = longint'(x & 32'hFFF); if (t >= 2048) t -= 4096; end
      3'd2: t = longint'(x & 32'h3FFFF);
      3'd3: begin
        t = longint'(x & 32'h3FFFFF) * 1024;
        if (t >= 64'sd2147483648) t -= 64'sd4294967296;
      end
      3'd4: begin t = longint'(x & 32'h3FFF); if (t >= 8192) t -= 16384; t = t * 4; end
      3'd6: t = longint'(x & 32'h3FF);
      default: t = 0;
    endcase
    return DW'(t);
  endfunction

  task automatic model_reset();
    m_ov = 0; m_imm = '0; m_tag = '0; m_fused = 0;
    m_st = 0; m_pend = '0; m_ptag = '0; m_cnt = 0; m_sp = '0; m_stag = '0;
  endtask

  task automatic memit(input logic [DW-1:0] i, input logic [TW-1:0] tg, input bit fu);
    m_ov = 1; m_imm = i; m_tag = tg; m_fused = fu;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pop_chk(input string nm, input logic [63:0] imm, input logic [TW-1:0] tg, input bit fu);
    if (xlog.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: got no output expected %0h", nm, imm);
    end else begin
      xfer_t e;
      e = xlog.pop_front();
      chk({nm, "_imm"}, e.imm, imm);
      chk({nm, "_tag"}, 64'(e.tag), 64'(tg));
      chk({nm, "_fused"}, 64'(e.fused), 64'(fu));
    end
  endtask

  // One clock: drive, compare at negedge, advance model, return at posedge+1.
  task automatic step(input bit v, input logic [2:0] f, input logic [31:0] x,
                      input logic [TW-1:0] t, input bit ordy, input bit fl);
    bit slot, ir, acc;
    logic [DW-1:0] ri;
    in_valid = v; in_fmt = f; in_instr = x; in_tag = t; out_ready = ordy; flush = fl;
    @(negedge clk);
    slot = !m_ov || ordy;
    ir   = !fl && (m_st != 2) && slot;
    acc  = v && ir;
    ri   = ref_imm(f, x);
    chk("in_ready", 64'(in_ready), 64'(ir));
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    if (m_ov) begin
      chk("out_imm", out_imm, m_imm);
      chk("out_tag", 64'(out_tag), 64'(m_tag));
      chk("out_fused", 64'(out_fused), 64'(m_fused));
    end
    s_ir = in_ready;
    if (out_valid && out_ready) xlog.push_back('{imm: out_imm, tag: out_tag, fused: out_fused});
    if (slot) m_ov = 0;
    if (fl) begin
      m_ov = 0; m_st = 0; m_cnt = 0;
    end else if (!FUSE) begin
      if (acc) memit(ri, t, 0);
    end else begin
      case (m_st)
        0: if (acc) begin
          if (f == 3'd3) begin m_pend = ri; m_ptag = t; m_cnt = 0; m_st = 1; end
          else memit(ri, t, 0);
        end
        1: if (acc) begin
          m_cnt = 0;
          if (f == 3'd6) begin memit(m_pend + ri, m_ptag, 1); m_st = 0; end
          else begin
            memit(m_pend, m_ptag, 0);
            if (f == 3'd3) begin m_pend = ri; m_ptag = t; end
            else begin m_sp = ri; m_stag = t; m_st = 2; end
          end
        end else if (m_cnt == HM) begin
          if (slot) begin memit(m_pend, m_ptag, 0); m_st = 0; m_cnt = 0; end
        end else m_cnt++;
        default: if (slot) begin memit(m_sp, m_stag, 0); m_st = 0; end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 3'd0, 32'h0, '0, 1, 0);
  endtask

  initial begin
    int  j;
    bit  seen;
    model_reset();
    #2;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_out_tag", 64'(out_tag), 0);
    chk("rst_out_fused", 64'(out_fused), 0);
    chk("rst_in_ready", 64'(in_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;

    // Format table, back to back with out_ready high.
    xlog.delete();
    step(1, 3'd1, 32'h00000FFF, 4'd1, 1, 0);
    step(1, 3'd2, 32'h0003FFFF, 4'd2, 1, 0);
`ifndef IMM_FUSE_EN
    step(1, 3'd3, 32'h003FFFFF, 4'd3, 1, 0);
    step(1, 3'd6, 32'h000003FF, 4'd4, 1, 0);
`endif
    step(1, 3'd4, 32'h00002000, 4'd5, 1, 0);
    step(1, 3'd1, 32'h00000800, 4'd6, 1, 0);
    step(1, 3'd0, 32'hFFFFFFFF, 4'd7, 1, 0);
    idle(2);
    pop_chk("s12", 64'hFFFFFFFFFFFFFFFF, 4'd1, 0);
    pop_chk("u18", 64'h000000000003FFFF, 4'd2, 0);
`ifndef IMM_FUSE_EN
    pop_chk("upper", 64'hFFFFFFFFFFFFFC00, 4'd3, 0);
    pop_chk("low10", 64'h00000000000003FF, 4'd4, 0);
`endif
    pop_chk("br14", 64'hFFFFFFFFFFFF8000, 4'd5, 0);
    pop_chk("s12_w64", 64'hFFFFFFFFFFFFF800, 4'd6, 0);
    pop_chk("none", 64'h0, 4'd7, 0);

    // Backpressure: three stalled cycles, then release.
    xlog.delete();
    step(1, 3'd1, 32'h1, 4'd5, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, 3'd1, 32'h2, 4'd6, 0, 0);
      chk("bp_ready_low", 64'(s_ir), 0);
    end
    chk("bp_hold_imm", out_imm, 64'h1);
    step(1, 3'd1, 32'h2, 4'd6, 1, 0);
    idle(2);
    chk("bp_count", 64'(xlog.size()), 2);
    pop_chk("bp_first", 64'h1, 4'd5, 0);
    pop_chk("bp_second", 64'h2, 4'd6, 0);

`ifdef IMM_FUSE_EN
    xlog.delete();
    step(1, 3'd3, 32'h00012345, 4'd3, 1, 0);
    step(1, 3'd6, 32'h000003FF, 4'd4, 1, 0);
    idle(2);
    chk("fuse_count", 64'(xlog.size()), 1);
    pop_chk("fuse", 64'h00000000048D17FF, 4'd3, 1);

    xlog.delete();
    step(1, 3'd3, 32'h00012345, 4'd1, 1, 0);
    step(1, 3'd1, 32'h00000FFF, 4'd2, 1, 0);
    step(1, 3'd1, 32'h00000005, 4'd7, 1, 0);
    chk("spill_ready_low", 64'(s_ir), 0);
    step(1, 3'd1, 32'h00000005, 4'd7, 1, 0);
    chk("spill_ready_back", 64'(s_ir), 1);
    idle(2);
    pop_chk("spill_pend", 64'h00000000048D1400, 4'd1, 0);
    pop_chk("spill_entry", 64'hFFFFFFFFFFFFFFFF, 4'd2, 0);
    pop_chk("spill_next", 64'h5, 4'd7, 0);

    // Counter runs 0..HM over the idle cycles; the release edge follows,
    // so the output first shows on idle step HM+2.
    xlog.delete();
    step(1, 3'd3, 32'h00000001, 4'd9, 1, 0);
    j = 0; seen = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      idle(1);
      if (xlog.size() != 0) begin seen = 1; j = k; end
    end
    chk("timeout_step", 64'(j), 64'(HM + 2));
    pop_chk("timeout", 64'h400, 4'd9, 0);

    xlog.delete();
    step(1, 3'd3, 32'h00012345, 4'd10, 1, 0);
    step(0, 3'd0, 32'h0, '0, 1, 1);
    idle(8);
    chk("flush_no_emit", 64'(xlog.size()), 0);
    step(1, 3'd6, 32'h00000003, 4'd1, 1, 0);
    idle(2);
    pop_chk("post_flush_low", 64'h3, 4'd1, 0);
`endif

    // Asynchronous reset while an output is stalled.
    step(1, 3'd1, 32'h000007FF, 4'd2, 0, 0);
    chk("pre_rst_valid", 64'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 0);
    chk("midrst_imm", out_imm, 0);
    chk("midrst_ready", 64'(in_ready), 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;

    for (int k = 0; k < 3000; k++) begin
      int r;
      logic [2:0] f;
      r = int'($urandom % 10);
      f = (r < 3) ? 3'd3 : (r < 6) ? 3'd6 : 3'($urandom_range(0, 7));
      step(($urandom % 4) != 0, f, $urandom, TW'($urandom), ($urandom % 4) != 0,
           ($urandom % 32) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Registered, flow-controlled successor to the combinational immediate generator, parametrised in output width and tag width. Sits between instruction decode and operand fetch. Accepts one instruction per cycle together with a decoder-supplied immediate format, and emits the sign- or zero-extended immediate with valid/ready handshaking and pipeline flush. Can optionally fuse an upper-immediate/low-immediate instruction pair into one immediate.

Parameters:
DATA_W, 32, output immediate width; legal range >= 32; values are sign-extended from 32-bit bit 0.
TAG_W, 4, width of the opaque tag carried alongside each instruction.
HOLD_MAX, 4, idle cycles a pending upper immediate waits for a partner (fusion build only); legal range >= 1.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline flush, priority over all handshakes
in_valid  in  1  upstream instruction valid
in_ready  out  1  block can accept this cycle
in_instr  in  [0:31]  instruction word, bit 0 = MSB
in_fmt  in  3  format: 0 NONE, 1 S12, 2 U18, 3 UPPER, 4 BR14, 5 S12 (reserved alias), 6 LOW10, 7 NONE
in_tag  in  TAG_W  opaque tag
out_valid  out  1  immediate valid
out_ready  in  1  downstream accepts
out_imm  out  [0:DATA_W-1]  generated immediate
out_tag  out  TAG_W  tag of the producing instruction
out_fused  out  1  out_imm is a fused UPPER+LOW10 pair

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_imm=0, out_tag=0, out_fused=0; state IDLE; pending/spill registers cleared; HOLD counter=0. in_ready is 0 while rst_n=0.
- Format arithmetic, 32-bit intermediate, then sign-extended from bit 0 to DATA_W:
  - NONE: 0.
  - S12: sext(instr[20:31]).
  - U18: zext(instr[14:31]).
  - UPPER: instr[10:31] << 10.
  - BR14: sext(instr[18:31]) << 2.
  - LOW10: zext(instr[22:31]).
- Latency: 1 cycle. An instruction accepted at edge N appears on out_* after edge N.
- Output register loads when empty or when out_ready=1. It holds stable while out_valid=1 and out_ready=0.
- in_ready = !flush && state!=SPILL && (!out_valid || out_ready).
- flush=1: at the next edge, out_valid=0, state returns to IDLE, pending and spill are discarded, no input is accepted. Flush and handshake in the same cycle: flush wins.
- Without fusion, state stays IDLE always.

Optional Feature:
IMM_FUSE_EN defined: three-state FSM IDLE/HOLD/SPILL.
- IDLE + accept UPPER: store value and tag in the pending register, emit nothing, go HOLD, counter=0.
- HOLD + accept LOW10: emit pending|low10 with the UPPER's tag and out_fused=1, go IDLE.
- HOLD + accept UPPER: emit old pending standalone; the new UPPER becomes pending; stay HOLD.
- HOLD + accept any other format: emit pending standalone, latch the new instruction in spill, go SPILL.
- SPILL: in_ready=0. When the output slot frees, emit the spill entry and go IDLE.
- HOLD + no accept: counter increments each cycle. At counter=HOLD_MAX and the output slot free, emit pending standalone and go IDLE.
IMM_FUSE_EN undefined: UPPER and LOW10 are emitted individually; out_fused is tied to 0; no pending, spill, or counter logic.

Test Plan:
- Reset mid-stream: out_valid=1 with out_ready=0, assert rst_n=0 -> out_valid=0, out_imm=0 immediately, without waiting for a clock edge.
- Formats, one per cycle, out_ready=1:
  - S12 0x00000FFF -> 0xFFFFFFFF.
  - U18 0x0003FFFF -> 0x0003FFFF.
  - UPPER 0x003FFFFF -> 0xFFFFFC00 (no fusion build).
  - BR14 0x00002000 -> 0xFFFF8000.
  - DATA_W=64, S12 0x00000800 -> 0xFFFFFFFFFFFFF800.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_imm stable; on release, items appear in order, none lost or duplicated.
- Fusion (IMM_FUSE_EN): UPPER 0x00012345 tag 3, then LOW10 0x000003FF tag 4 -> single output 0x048D17FF, tag 3, out_fused=1.
- Fusion spill: UPPER 0x00012345, then S12 0x00000FFF -> 0x048D1400 (fused=0), then 0xFFFFFFFF; in_ready=0 for exactly the SPILL cycle.
- Timeout and flush: UPPER, then in_valid=0 -> standalone emission after HOLD_MAX=4 idle cycles. Flush asserted while in HOLD -> no emission, state IDLE.
